// File: rtl/pipeline_ctrl_pkg.sv
// Shared stall-vector layout, FSM encoding and stall-merge helper for pipeline_ctrl.
package pipeline_ctrl_pkg;

    localparam int unsigned STALL_W = 6;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned FCNT_W  = 4;

    localparam int unsigned STALL_PC    = 0;
    localparam int unsigned STALL_IF_ID = 1;
    localparam int unsigned STALL_ID_EX = 2;
    localparam int unsigned STALL_EX_MEM = 3;
    localparam int unsigned STALL_MEM_WB = 4;
    localparam int unsigned STALL_WB    = 5;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REFILL = 2'd2
    } ctrl_state_e;

    // Deepest requesting stage wins; it freezes itself and every earlier latch.
    function automatic logic [STALL_W-1:0] merge_stall(input logic req_id,
                                                       input logic req_ex,
                                                       input logic req_mem);
        logic [STALL_W-1:0] vec;
        vec = STALL_NONE;
        if (req_mem)      vec = STALL_MEM;
        else if (req_ex)  vec = STALL_EX;
        else if (req_id)  vec = STALL_ID;
        return vec;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Saturating count of consecutive stalled cycles with a sticky timeout flag.
module stall_watchdog #(
    parameter int unsigned WDOG_W     = 8,
    parameter int unsigned WDOG_LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_any,
    output logic timeout
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(WDOG_LIMIT);
    localparam logic [WDOG_W-1:0] ONE   = WDOG_W'(1);

    logic [WDOG_W-1:0] cnt;

    // Timeout is set on the same edge the counter lands on LIMIT and only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else if (!stall_any) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + ONE;
            if (cnt == LIMIT - ONE) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stall merge, flush/redirect FSM, stall watchdog.
// Optional performance counters are built when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned WDOG_LIMIT   = 255,
    parameter int unsigned WDOG_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic               flush_req,
    input  logic [PC_W-1:0]    flush_pc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [PC_W-1:0]    new_pc,
    output logic               new_pc_valid,
    output logic               busy,
    output logic               wdog_timeout
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_flush_count
`endif
);

    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FCNT_ONE   = FCNT_W'(1);

    ctrl_state_e       state;
    logic [FCNT_W-1:0] fcnt;
    logic              stall_any;
    logic              flush_start;

    // Stall is a same-cycle decode of the requests, suppressed outside RUN.
    assign stall       = (state == ST_RUN) ? merge_stall(stallreq_id, stallreq_ex, stallreq_mem)
                                           : STALL_NONE;
    assign stall_any   = |stall;
    assign flush_start = (state == ST_RUN) && flush_req;

    // Flush sequencer; outputs are updated alongside the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_RUN;
            fcnt         <= '0;
            flush        <= 1'b0;
            new_pc       <= '0;
            new_pc_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            new_pc_valid <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (flush_req) begin
                        state        <= ST_FLUSH;
                        fcnt         <= FLUSH_LOAD;
                        new_pc       <= flush_pc;
                        new_pc_valid <= 1'b1;
                        flush        <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (fcnt == '0) begin
                        state <= ST_REFILL;
                        flush <= 1'b0;
                    end else begin
                        fcnt <= fcnt - FCNT_ONE;
                    end
                end
                ST_REFILL: begin
                    state <= ST_RUN;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_RUN;
                    flush <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    stall_watchdog #(
        .WDOG_W    (WDOG_W),
        .WDOG_LIMIT(WDOG_LIMIT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .stall_any(stall_any),
        .timeout  (wdog_timeout)
    );

`ifdef PIPELINE_CTRL_PERF_EN
    // Free-running event counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (stall_any) begin
                perf_stall_cycles <= perf_stall_cycles + 32'(1);
            end
            if (flush_start) begin
                perf_flush_count <= perf_flush_count + 32'(1);
            end
        end
    end
`else
    logic unused_flush_start;
    assign unused_flush_start = flush_start;
`endif

endmodule
